// File: rtl/shot_clock_ctrl.sv
// Shot-clock sequencing controller.
// Conditions the start/pause and reset pushbuttons, runs the IDLE/RUN/PAUSE/EXPIRED
// state machine, and drives load, load_val, the 1 s decrement strobe and the
// decimal-point flash used once the countdown has expired.
module shot_clock_ctrl #(
    parameter int         TICK_DIV   = 50_000_000,
    parameter int         FLASH_DIV  = 25_000_000,
    parameter int         DEB_CYCLES = 500_000,
    parameter logic [7:0] PRESET_HI  = 8'd30,
    parameter logic [7:0] PRESET_LO  = 8'd24
) (
    input  logic       cin,
    input  logic       rst_n,
    input  logic       btn_run_n,
    input  logic       btn_rst_n,
    input  logic       sw,
    input  logic       cnt_zero,
    output logic       load,
    output logic [7:0] load_val,
    output logic       dec_en,
    output logic       flash,
    output logic [1:0] state
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_PAUSE   = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    localparam int PW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
    localparam int FW = (FLASH_DIV  > 1) ? $clog2(FLASH_DIV)  : 1;
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);

    // Button index 0 is start/pause, index 1 is count-reset.
    logic [1:0]    btn_raw;
    logic [1:0]    btn_p0;
    logic [1:0]    btn_p1;
    logic [1:0]    deb_lvl;
    logic [1:0]    press;
    logic [DW-1:0] deb_cnt [2];

    logic          run_ev;
    logic          rst_ev;
    logic          enter_exp;
    logic [PW-1:0] presc;
    logic          dec_p1;
    logic [FW-1:0] flash_cnt;

    assign btn_raw = {btn_rst_n, btn_run_n};

    // Synchronize both buttons, debounce them, and emit a one-cycle pulse on each accepted press.
    always_ff @(posedge cin) begin
        if (!rst_n) begin
            btn_p0  <= 2'b11;
            btn_p1  <= 2'b11;
            deb_lvl <= 2'b11;
            press   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            // stage p0 -> p1: two-flop synchronizer
            btn_p0 <= btn_raw;
            btn_p1 <= btn_p0;
            // stage p1 -> debounced level and press pulse
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (btn_p1[i] == deb_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_cnt[i] <= '0;
                    deb_lvl[i] <= btn_p1[i];
                    // Only the released->pressed (1->0) change is an event.
                    press[i]   <= deb_lvl[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign run_ev    = press[0];
    assign rst_ev    = press[1];
    assign enter_exp = (state == S_RUN) && cnt_zero && !rst_ev;

    assign load     = (state == S_IDLE);
    assign load_val = sw ? PRESET_HI : PRESET_LO;
    // A strobe registered on the wrap is suppressed if the count has meanwhile hit zero.
    assign dec_en   = dec_p1 & ~cnt_zero;

    // Run/pause/expire state machine with the 1 s prescaler and registered decrement strobe.
    always_ff @(posedge cin) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            presc  <= '0;
            dec_p1 <= 1'b0;
        end else begin
            dec_p1 <= 1'b0;
            if (rst_ev) begin
                state <= S_IDLE;
                presc <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (run_ev) begin
                            state <= S_RUN;
                            presc <= '0;
                        end
                    end
                    S_RUN: begin
                        if (cnt_zero) begin
                            state <= S_EXPIRED;
                            presc <= '0;
                        end else if (run_ev) begin
                            // Prescaler holds so the resumed second is only partially restarted.
                            state <= S_PAUSE;
                        end else if (presc == PRE_LAST) begin
                            presc  <= '0;
                            dec_p1 <= 1'b1;
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    S_PAUSE: begin
                        if (run_ev) begin
                            state <= S_RUN;
                        end
                    end
                    default: begin
                        // EXPIRED: start/pause is ignored, only a reset event leaves.
                        state <= S_EXPIRED;
                    end
                endcase
            end
        end
    end

    // Decimal-point flash: lit on entry to EXPIRED, toggles every FLASH_DIV cycles, dark elsewhere.
    always_ff @(posedge cin) begin
        if (!rst_n) begin
            flash     <= 1'b0;
            flash_cnt <= '0;
        end else if (enter_exp) begin
            flash     <= 1'b1;
            flash_cnt <= '0;
        end else if ((state == S_EXPIRED) && !rst_ev) begin
            if (flash_cnt == FLASH_LAST) begin
                flash_cnt <= '0;
                flash     <= ~flash;
            end else begin
                flash_cnt <= flash_cnt + FW'(1);
            end
        end else begin
            flash     <= 1'b0;
            flash_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Directed bench for shot_clock_ctrl with short dividers (TICK_DIV=10, FLASH_DIV=5, DEB_CYCLES=3).
// Expected strobe cycles and flash values are queued when stimulus is applied and
// consumed as the design produces output.
module tb_shot_clock_ctrl;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_PAUSE   = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    logic       cin = 1'b0;
    logic       rst_n;
    logic       btn_run_n;
    logic       btn_rst_n;
    logic       sw;
    logic       cnt_zero;
    logic       load;
    logic [7:0] load_val;
    logic       dec_en;
    logic       flash;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int dec_q[$];
    logic flash_q[$];

    shot_clock_ctrl #(
        .TICK_DIV  (10),
        .FLASH_DIV (5),
        .DEB_CYCLES(3),
        .PRESET_HI (8'd30),
        .PRESET_LO (8'd24)
    ) dut (
        .cin      (cin),
        .rst_n    (rst_n),
        .btn_run_n(btn_run_n),
        .btn_rst_n(btn_rst_n),
        .sw       (sw),
        .cnt_zero (cnt_zero),
        .load     (load),
        .load_val (load_val),
        .dec_en   (dec_en),
        .flash    (flash),
        .state    (state)
    );

    always #5 cin = ~cin;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 ns later, and compare dec_en against the strobe queue.
    task automatic tick();
        @(posedge cin);
        #1;
        cyc++;
        if (dec_q.size() > 0 && dec_q[0] == cyc) begin
            check("dec_en_strobe", {31'd0, dec_en}, 32'd1);
            void'(dec_q.pop_front());
        end else begin
            check("dec_en_quiet", {31'd0, dec_en}, 32'd0);
        end
    endtask

    task automatic wait_state(input string tag, input logic [1:0] tgt, input int limit, output int at);
        int n = 0;
        while (state !== tgt && n < limit) begin
            tick();
            n++;
        end
        check(tag, {30'd0, state}, {30'd0, tgt});
        at = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int c, e, p, r, h, x, e2, e3;

        rst_n     = 1'b0;
        btn_run_n = 1'b1;
        btn_rst_n = 1'b1;
        sw        = 1'b1;
        cnt_zero  = 1'b0;

        // Reset and IDLE preset selection
        repeat (3) tick();
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_load", {31'd0, load}, 32'd1);
        check("rst_load_val", {24'd0, load_val}, 32'd30);
        check("rst_flash", {31'd0, flash}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_val_hi", {24'd0, load_val}, 32'd30);
        sw = 1'b0;
        #1;
        check("idle_val_lo", {24'd0, load_val}, 32'd24);
        check("idle_load", {31'd0, load}, 32'd1);
        repeat (3) tick();
        check("idle_state", {30'd0, state}, 32'd0);

        // Clean run press held for 8 cycles
        btn_run_n = 1'b0;
        c = cyc;
        wait_state("run_start", S_RUN, 12, e);
        dec_q.push_back(e + 10);
        dec_q.push_back(e + 20);
        dec_q.push_back(e + 30);
        while (cyc < c + 8) tick();
        btn_run_n = 1'b1;
        while (cyc < e + 31) tick();
        check("run_hold_state", {30'd0, state}, 32'd1);

        // Pause mid-second, dwell, resume
        btn_run_n = 1'b0;
        c = cyc;
        wait_state("pause", S_PAUSE, 12, p);
        h = (p - 1 - e) % 10;
        while (cyc < c + 8) tick();
        btn_run_n = 1'b1;
        while (cyc < p + 50) begin
            tick();
            check("pause_state", {30'd0, state}, 32'd2);
        end
        btn_run_n = 1'b0;
        c = cyc;
        wait_state("resume", S_RUN, 12, r);
        dec_q.push_back(r + 10 - h);
        dec_q.push_back(r + 20 - h);
        while (cyc < c + 8) tick();
        btn_run_n = 1'b1;
        while (cyc < r + 20 - h) tick();

        // Expire: flash pattern, run press ignored
        cnt_zero = 1'b1;
        for (int k = 0; k < 20; k++) flash_q.push_back(((k / 5) % 2) == 0);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("exp_state", {30'd0, state}, 32'd3);
            check("exp_flash", {31'd0, flash}, {31'd0, flash_q.pop_front()});
            if (k == 1) btn_run_n = 1'b0;
            if (k == 9) btn_run_n = 1'b1;
        end

        // Reset button leaves EXPIRED
        btn_rst_n = 1'b0;
        c = cyc;
        wait_state("rst_from_exp", S_IDLE, 12, x);
        check("rst_exp_flash", {31'd0, flash}, 32'd0);
        check("rst_exp_load", {31'd0, load}, 32'd1);
        cnt_zero = 1'b0;
        while (cyc < c + 8) tick();
        btn_rst_n = 1'b1;
        repeat (6) tick();
        check("idle_flash_dark", {31'd0, flash}, 32'd0);

        // Run and reset pressed together during RUN
        btn_run_n = 1'b0;
        c = cyc;
        wait_state("run_again", S_RUN, 12, e2);
        dec_q.push_back(e2 + 10);
        while (cyc < c + 8) tick();
        btn_run_n = 1'b1;
        while (cyc < e2 + 11) tick();
        btn_run_n = 1'b0;
        btn_rst_n = 1'b0;
        c = cyc;
        wait_state("both_press", S_IDLE, 12, x);
        check("both_load", {31'd0, load}, 32'd1);
        while (cyc < c + 8) tick();
        btn_run_n = 1'b1;
        btn_rst_n = 1'b1;
        repeat (10) tick();
        check("both_stay_idle", {30'd0, state}, 32'd0);

        // Two-cycle glitch on start/pause
        btn_run_n = 1'b0;
        tick();
        tick();
        btn_run_n = 1'b1;
        repeat (15) tick();
        check("glitch_idle", {30'd0, state}, 32'd0);

        // rst_n pulse just as the prescaler would wrap
        btn_run_n = 1'b0;
        c = cyc;
        wait_state("run_third", S_RUN, 12, e3);
        while (cyc < c + 8) tick();
        btn_run_n = 1'b1;
        while (cyc < e3 + 9) tick();
        rst_n = 1'b0;
        tick();
        check("rstn_state", {30'd0, state}, 32'd0);
        check("rstn_flash", {31'd0, flash}, 32'd0);
        check("rstn_dec", {31'd0, dec_en}, 32'd0);
        check("rstn_load", {31'd0, load}, 32'd1);
        rst_n = 1'b1;
        repeat (15) tick();
        check("rstn_after_state", {30'd0, state}, 32'd0);
        check("dec_q_drained", dec_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
